// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit check, dispense handshake, greedy change, clear.
// Optional build macro VEND_TIMEOUT_EN adds an idle-credit refund timeout.
module vend_controller #(
    parameter logic [6:0]  PRICE_0        = 7'd35,
    parameter logic [6:0]  PRICE_1        = 7'd50,
    parameter logic [6:0]  PRICE_2        = 7'd65,
    parameter logic [6:0]  PRICE_3        = 7'd75,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] total,
    input  logic       select,
    input  logic [1:0] item_sel,
    input  logic       cancel,
    input  logic       dispense_done,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic       eject_25,
    output logic       eject_10,
    output logic       eject_5,
    output logic       clear,
    output logic       coin_lock,
    output logic       insufficient,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_VEND,
        S_CHANGE,
        S_CLEAR
    } state_t;

    state_t     r_state;
    logic [6:0] r_credit;
    logic [6:0] r_rem;
    logic       r_busy;
    logic [6:0] w_price;
    logic       w_timeout;
    logic       w_refund;

    always_comb begin
        w_price = PRICE_0;
        case (item_out)
            2'd0: w_price = PRICE_0;
            2'd1: w_price = PRICE_1;
            2'd2: w_price = PRICE_2;
            2'd3: w_price = PRICE_3;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_idle_cnt;
    logic [6:0]    r_prev_total;
    logic          w_idle_hold;

    // Counter only advances while idle credit sits unchanged and untouched
    assign w_idle_hold = (r_state == S_IDLE) && (total != 7'd0)
                      && (total == r_prev_total) && !select && !cancel;
    assign w_timeout = w_idle_hold
                    && (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt   <= '0;
            r_prev_total <= 7'd0;
        end else begin
            r_prev_total <= total;
            if (!w_idle_hold || w_timeout)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    assign w_refund  = (cancel || w_timeout) && (total != 7'd0);
    assign busy      = r_busy;
    assign coin_lock = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_credit     <= 7'd0;
            r_rem        <= 7'd0;
            r_busy       <= 1'b0;
            item_out     <= 2'd0;
            dispense     <= 1'b0;
            eject_25     <= 1'b0;
            eject_10     <= 1'b0;
            eject_5      <= 1'b0;
            clear        <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            eject_25     <= 1'b0;
            eject_10     <= 1'b0;
            eject_5      <= 1'b0;
            clear        <= 1'b0;
            insufficient <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_refund) begin
                        r_rem   <= total;
                        r_state <= S_CHANGE;
                        r_busy  <= 1'b1;
                    end else if (select) begin
                        r_credit <= total;
                        item_out <= item_sel;
                        r_state  <= S_CHECK;
                        r_busy   <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (r_credit >= w_price) begin
                        r_rem    <= r_credit - w_price;
                        r_state  <= S_VEND;
                        dispense <= 1'b1;
                    end else begin
                        insufficient <= 1'b1;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                S_VEND: begin
                    if (dispense_done) begin
                        dispense <= 1'b0;
                        r_state  <= S_CHANGE;
                    end
                end
                S_CHANGE: begin
                    if (r_rem >= 7'd25) begin
                        eject_25 <= 1'b1;
                        r_rem    <= r_rem - 7'd25;
                    end else if (r_rem >= 7'd10) begin
                        eject_10 <= 1'b1;
                        r_rem    <= r_rem - 7'd10;
                    end else if (r_rem >= 7'd5) begin
                        eject_5 <= 1'b1;
                        r_rem   <= r_rem - 7'd5;
                    end else begin
                        clear   <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    dispense <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Randomized and directed bench for vend_controller.
// Expected behaviour comes from a transaction-level model of prices and greedy change.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] total = 7'd0;
    logic       select = 1'b0;
    logic [1:0] item_sel = 2'd0;
    logic       cancel = 1'b0;
    logic       dispense_done = 1'b0;
    logic       dispense;
    logic [1:0] item_out;
    logic       eject_25, eject_10, eject_5;
    logic       clear, coin_lock, insufficient, busy;

    vend_controller #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .total(total),
        .select(select),
        .item_sel(item_sel),
        .cancel(cancel),
        .dispense_done(dispense_done),
        .dispense(dispense),
        .item_out(item_out),
        .eject_25(eject_25),
        .eject_10(eject_10),
        .eject_5(eject_5),
        .clear(clear),
        .coin_lock(coin_lock),
        .insufficient(insufficient),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    int prices[4] = '{35, 50, 65, 75};

    // model results
    int exp_ej[$];
    bit exp_active, exp_vend, exp_ins;

    // observed trace of one transaction
    int obs_ej[$];
    int obs_ej_t[$];
    int obs_clr_cnt, obs_clr_t, obs_ins_cnt, obs_ins_t;
    int obs_disp_cnt, obs_disp_first, obs_done_t;
    int obs_item, obs_lock_bad;
    bit obs_busy0, obs_hung;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_txn(input int tot, input bit sel, input int it, input bit can);
        int rem;
        rem = -1;
        exp_ej.delete();
        exp_active = 0;
        exp_vend = 0;
        exp_ins = 0;
        if (can && tot != 0) begin
            exp_active = 1;
            rem = tot;
        end else if (sel) begin
            exp_active = 1;
            if (tot >= prices[it]) begin
                exp_vend = 1;
                rem = tot - prices[it];
            end else begin
                exp_ins = 1;
            end
        end
        if (rem >= 0) begin
            repeat (rem / 25) exp_ej.push_back(25);
            rem = rem % 25;
            repeat (rem / 10) exp_ej.push_back(10);
            rem = rem % 10;
            repeat (rem / 5) exp_ej.push_back(5);
        end
    endtask

    task automatic run_txn(input int tot, input bit sel, input int it,
                           input bit can, input int dly, input bit noise);
        int t;
        int seen;
        bit done;
        total = 7'(tot);
        select = sel;
        item_sel = 2'(it);
        cancel = can;
        step();
        select = 0;
        cancel = 0;
        obs_ej.delete();
        obs_ej_t.delete();
        obs_clr_cnt = 0; obs_clr_t = -1;
        obs_ins_cnt = 0; obs_ins_t = -1;
        obs_disp_cnt = 0; obs_disp_first = -1;
        obs_done_t = -1; obs_item = -1; obs_lock_bad = 0;
        obs_busy0 = busy;
        obs_hung = 1;
        seen = 0;
        done = 0;
        t = 0;
        while (t < 80 && !done) begin
            if (eject_25) begin obs_ej.push_back(25); obs_ej_t.push_back(t); end
            if (eject_10) begin obs_ej.push_back(10); obs_ej_t.push_back(t); end
            if (eject_5)  begin obs_ej.push_back(5);  obs_ej_t.push_back(t); end
            if (clear) begin obs_clr_cnt++; obs_clr_t = t; end
            if (insufficient) begin obs_ins_cnt++; obs_ins_t = t; end
            if (coin_lock !== busy) obs_lock_bad++;
            dispense_done = 0;
            if (dispense) begin
                if (obs_disp_first < 0) begin
                    obs_disp_first = t;
                    obs_item = int'(item_out);
                end
                obs_disp_cnt++;
                seen++;
                if (seen == dly) begin
                    dispense_done = 1;
                    obs_done_t = t;
                end
            end
            if (noise && busy) begin
                total = 7'($urandom_range(0, 127));
                select = 1'($urandom_range(0, 1));
                cancel = 1'($urandom_range(0, 1));
                item_sel = 2'($urandom_range(0, 3));
                if (!dispense) dispense_done = 1'($urandom_range(0, 1));
            end else begin
                select = 0;
                cancel = 0;
            end
            if (!busy) begin
                done = 1;
                obs_hung = 0;
            end else begin
                step();
                t++;
            end
        end
        select = 0;
        cancel = 0;
        dispense_done = 0;
        total = 7'(tot);
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        n_total++;
        if ({dispense, eject_25, eject_10, eject_5, clear, coin_lock, insufficient, busy} !== 8'h00) begin
            $display("FAIL reset_outputs got %b want 00000000",
                     {dispense, eject_25, eject_10, eject_5, clear, coin_lock, insufficient, busy});
        end else n_pass++;
        n_total++;
        if (item_out !== 2'd0) $display("FAIL reset_item got %0d want 0", item_out);
        else n_pass++;
        reset = 0;
        step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_exact_change();
        run_txn(35, 1, 0, 0, 3, 0);
        n_total++;
        if (obs_hung || obs_disp_cnt != 3 || obs_disp_first != 1)
            $display("FAIL exact_dispense got cnt=%0d first=%0d hung=%0d want cnt=3 first=1",
                     obs_disp_cnt, obs_disp_first, obs_hung);
        else n_pass++;
        n_total++;
        if (obs_ej.size() != 0) $display("FAIL exact_noeject got %0d ejects want 0", obs_ej.size());
        else n_pass++;
        n_total++;
        if (obs_clr_cnt != 1 || obs_clr_t != obs_done_t + 2)
            $display("FAIL exact_clear got cnt=%0d t=%0d want cnt=1 t=%0d",
                     obs_clr_cnt, obs_clr_t, obs_done_t + 2);
        else n_pass++;
    endtask

    task automatic test_change();
        run_txn(50, 1, 0, 0, 2, 0);
        n_total++;
        if (obs_ej.size() != 2) $display("FAIL change_count got %0d want 2", obs_ej.size());
        else n_pass++;
        n_total++;
        if (obs_ej.size() == 2 && (obs_ej[0] != 10 || obs_ej[1] != 5 ||
            obs_ej_t[0] != obs_done_t + 2 || obs_ej_t[1] != obs_done_t + 3))
            $display("FAIL change_seq got %0d@%0d %0d@%0d want 10@%0d 5@%0d", obs_ej[0],
                     obs_ej_t[0], obs_ej[1], obs_ej_t[1], obs_done_t + 2, obs_done_t + 3);
        else if (obs_ej.size() == 2) n_pass++;
        else $display("FAIL change_seq got wrong eject count");
        n_total++;
        if (obs_clr_cnt != 1 || obs_clr_t != obs_done_t + 4)
            $display("FAIL change_clear got cnt=%0d t=%0d want cnt=1 t=%0d",
                     obs_clr_cnt, obs_clr_t, obs_done_t + 4);
        else n_pass++;
    endtask

    task automatic test_insufficient();
        run_txn(30, 1, 2, 0, 1, 0);
        n_total++;
        if (obs_ins_cnt != 1 || obs_ins_t != 1)
            $display("FAIL insuff_pulse got cnt=%0d t=%0d want cnt=1 t=1", obs_ins_cnt, obs_ins_t);
        else n_pass++;
        n_total++;
        if (obs_disp_cnt != 0 || obs_clr_cnt != 0 || obs_ej.size() != 0)
            $display("FAIL insuff_quiet got disp=%0d clr=%0d ej=%0d want 0 0 0",
                     obs_disp_cnt, obs_clr_cnt, obs_ej.size());
        else n_pass++;
    endtask

    task automatic test_cancel_priority();
        run_txn(40, 1, 1, 1, 1, 0);
        n_total++;
        if (obs_ej.size() != 3) $display("FAIL cancel_count got %0d want 3", obs_ej.size());
        else n_pass++;
        n_total++;
        if (obs_ej.size() == 3 && !(obs_ej[0] == 25 && obs_ej[1] == 10 && obs_ej[2] == 5 &&
            obs_ej_t[0] == 1 && obs_ej_t[1] == 2 && obs_ej_t[2] == 3))
            $display("FAIL cancel_seq got %0d@%0d %0d@%0d %0d@%0d want 25@1 10@2 5@3",
                     obs_ej[0], obs_ej_t[0], obs_ej[1], obs_ej_t[1], obs_ej[2], obs_ej_t[2]);
        else if (obs_ej.size() == 3) n_pass++;
        else $display("FAIL cancel_seq got wrong eject count");
        n_total++;
        if (obs_clr_cnt != 1 || obs_clr_t != 4 || obs_disp_cnt != 0)
            $display("FAIL cancel_tail got clr=%0d@%0d disp=%0d want clr=1@4 disp=0",
                     obs_clr_cnt, obs_clr_t, obs_disp_cnt);
        else n_pass++;
        run_txn(0, 0, 0, 1, 1, 0);
        n_total++;
        if (obs_busy0 !== 1'b0) $display("FAIL cancel_zero busy got %b want 0", obs_busy0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_vend();
        int bad;
        total = 7'd35;
        select = 1;
        item_sel = 2'd0;
        step();
        select = 0;
        step();
        n_total++;
        if (dispense !== 1'b1) $display("FAIL midreset_pre dispense got %b want 1", dispense);
        else n_pass++;
        reset = 1;
        step();
        n_total++;
        if ({dispense, busy, coin_lock} !== 3'b000)
            $display("FAIL midreset_post got %b want 000", {dispense, busy, coin_lock});
        else n_pass++;
        reset = 0;
        bad = 0;
        repeat (4) begin
            step();
            if (clear || eject_25 || eject_10 || eject_5 || busy) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL midreset_quiet got %0d active cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_idle_credit();
        int bad;
        bad = 0;
        total = 7'd10;
        repeat (12) begin
            step();
            if (eject_10) bad++;
        end
`ifdef VEND_TIMEOUT_EN
        n_total++;
        if (bad != 1) $display("FAIL timeout_eject got %0d eject_10 want 1", bad);
        else n_pass++;
        total = 7'd0;
        repeat (4) step();
`else
        n_total++;
        if (bad != 0 || busy !== 1'b0)
            $display("FAIL hold_credit got ejects=%0d busy=%b want 0 0", bad, busy);
        else n_pass++;
        total = 7'd0;
        step();
`endif
    endtask

    task automatic test_back_to_back();
        run_txn(75, 1, 3, 0, 1, 0);
        run_txn(65, 1, 2, 0, 2, 0);
        n_total++;
        if (obs_busy0 !== 1'b1 || obs_disp_cnt != 2 || obs_item != 2 || obs_clr_cnt != 1)
            $display("FAIL b2b got busy0=%b disp=%0d item=%0d clr=%0d want 1 2 2 1",
                     obs_busy0, obs_disp_cnt, obs_item, obs_clr_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int tot, it, dly, k, start;
        bit sel, can, ok;
        for (int i = 0; i < 40; i++) begin
            tot = $urandom_range(0, 127);
            it = $urandom_range(0, 3);
            sel = ($urandom_range(0, 4) != 0);
            can = ($urandom_range(0, 3) == 0);
            dly = $urandom_range(1, 4);
            model_txn(tot, sel, it, can);
            run_txn(tot, sel, it, can, dly, 1);
            n_total++;
            if (obs_hung || obs_busy0 !== exp_active || obs_lock_bad != 0)
                $display("FAIL rand%0d state got busy0=%b hung=%0d lockbad=%0d want busy0=%b",
                         i, obs_busy0, obs_hung, obs_lock_bad, exp_active);
            else n_pass++;
            n_total++;
            if (obs_ins_cnt != int'(exp_ins) || (exp_ins && obs_ins_t != 1))
                $display("FAIL rand%0d insuff got %0d@%0d want %0d@1",
                         i, obs_ins_cnt, obs_ins_t, exp_ins);
            else n_pass++;
            n_total++;
            if (obs_disp_cnt != (exp_vend ? dly : 0) ||
                (exp_vend && (obs_disp_first != 1 || obs_item != it)))
                $display("FAIL rand%0d dispense got cnt=%0d first=%0d item=%0d want cnt=%0d item=%0d",
                         i, obs_disp_cnt, obs_disp_first, obs_item, exp_vend ? dly : 0, it);
            else n_pass++;
            k = exp_ej.size();
            start = exp_vend ? obs_done_t + 2 : 1;
            ok = (obs_ej.size() == k);
            if (ok) begin
                for (int j = 0; j < k; j++)
                    if (obs_ej[j] != exp_ej[j] || obs_ej_t[j] != start + j) ok = 0;
            end
            n_total++;
            if (!ok) $display("FAIL rand%0d change got %0d coins want %0d coins from total %0d",
                              i, obs_ej.size(), k, tot);
            else n_pass++;
            n_total++;
            if (exp_active && !exp_ins) begin
                if (obs_clr_cnt != 1 || obs_clr_t != start + k)
                    $display("FAIL rand%0d clear got %0d@%0d want 1@%0d",
                             i, obs_clr_cnt, obs_clr_t, start + k);
                else n_pass++;
            end else begin
                if (obs_clr_cnt != 0) $display("FAIL rand%0d clear got %0d want 0", i, obs_clr_cnt);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_change();
        test_change();
        test_insufficient();
        test_cancel_priority();
        test_reset_mid_vend();
        test_idle_credit();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
